// File: rtl/ld_pkg.sv
// Shared encodings for the sub-word load sequencer: size codes, FSM states and the
// request-fault check.
package ld_pkg;

   localparam logic [1:0] LD_BYTE = 2'b00;
   localparam logic [1:0] LD_HALF = 2'b01;
   localparam logic [1:0] LD_WORD = 2'b10;
   localparam logic [1:0] LD_RSVD = 2'b11;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StResp
   } ld_state_e;

   // A request that can never be served: reserved size or an unaligned half/word.
   function automatic logic ld_fault(input logic [1:0] size, input logic [1:0] off);
      return (size == LD_RSVD) ||
             ((size == LD_HALF) && off[0]) ||
             ((size == LD_WORD) && (off != 2'b00));
   endfunction

endpackage

// File: rtl/load_lane_extend.sv
// Little-endian lane select plus sign/zero extension of a memory word to 32 bits.
module load_lane_extend
   import ld_pkg::*;
(
   input  logic [31:0] data_i,
   input  logic [1:0]  off_i,
   input  logic [1:0]  size_i,
   input  logic        unsigned_i,
   output logic [31:0] out_o
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   assign byte_lane = data_i[8*off_i +: 8];
   assign half_lane = data_i[16*off_i[1] +: 16];

   always_comb begin
      out_o = data_i;
      case (size_i)
         LD_BYTE: out_o = {{24{~unsigned_i & byte_lane[7]}}, byte_lane};
         LD_HALF: out_o = {{16{~unsigned_i & half_lane[15]}}, half_lane};
         default: out_o = data_i;
      endcase
   end

endmodule

// File: rtl/load_extend_ctrl.sv
// Sub-word load sequencer: one word-aligned memory read per request, lane select and
// extension of the returned word, timeout abort and a one-cycle result pulse.
module load_extend_ctrl
   import ld_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        LdReq,
   input  logic [31:0] LdAddr,
   input  logic [1:0]  LdSize,
   input  logic        LdUnsigned,
   output logic        LdReady,
   output logic        MemRd,
   output logic [31:0] MemAddr,
   input  logic        MemAck,
   input  logic [31:0] MemRdata,
   output logic        LdValid,
   output logic [31:0] LdData,
   output logic        LdErr
);

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   ld_state_e   state_q, state_d;
   logic [1:0]  size_q, size_d;
   logic [1:0]  off_q, off_d;
   logic        uns_q, uns_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [31:0] memaddr_q, memaddr_d;
   logic [31:0] lddata_q, lddata_d;
   logic        lderr_q, lderr_d;
   logic        ready_q, memrd_q, valid_q;
   logic [31:0] ext_data;

   load_lane_extend u_extend (
      .data_i     (MemRdata),
      .off_i      (off_q),
      .size_i     (size_q),
      .unsigned_i (uns_q),
      .out_o      (ext_data)
   );

   always_comb begin
      state_d   = state_q;
      size_d    = size_q;
      off_d     = off_q;
      uns_d     = uns_q;
      cnt_d     = '0;
      memaddr_d = memaddr_q;
      lddata_d  = lddata_q;
      lderr_d   = lderr_q;
      case (state_q)
         StIdle: begin
            if (LdReq) begin
               size_d    = LdSize;
               off_d     = LdAddr[1:0];
               uns_d     = LdUnsigned;
               memaddr_d = {LdAddr[31:2], 2'b00};
               if (ld_fault(LdSize, LdAddr[1:0])) begin
                  state_d  = StResp;
                  lddata_d = '0;
                  lderr_d  = 1'b1;
               end else begin
                  state_d = StIssue;
               end
            end
         end
         StIssue: begin
            // Ack wins over a timeout firing in the same cycle.
            if (MemAck) begin
               state_d  = StResp;
               lddata_d = ext_data;
               lderr_d  = 1'b0;
            end else if (cnt_q == TO_LAST) begin
               state_d  = StResp;
               lddata_d = '0;
               lderr_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q   <= StIdle;
         size_q    <= LD_BYTE;
         off_q     <= 2'b00;
         uns_q     <= 1'b0;
         cnt_q     <= '0;
         memaddr_q <= '0;
         lddata_q  <= '0;
         lderr_q   <= 1'b0;
         ready_q   <= 1'b1;
         memrd_q   <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         size_q    <= size_d;
         off_q     <= off_d;
         uns_q     <= uns_d;
         cnt_q     <= cnt_d;
         memaddr_q <= memaddr_d;
         lddata_q  <= lddata_d;
         lderr_q   <= lderr_d;
         ready_q   <= (state_d == StIdle);
         memrd_q   <= (state_d == StIssue);
         valid_q   <= (state_d == StResp);
      end
   end

   assign LdReady = ready_q;
   assign MemRd   = memrd_q;
   assign MemAddr = memaddr_q;
   assign LdValid = valid_q;
   assign LdData  = lddata_q;
   assign LdErr   = lderr_q;

endmodule

// File: tb/tb_load_extend_ctrl.sv
// Scoreboard bench for load_extend_ctrl: expected results queued at accept, compared
// when LdValid pulses, with latency, MemRd duration and address checks per load.
module tb_load_extend_ctrl;

   localparam int unsigned TO = 4;

   logic        Clk = 1'b0;
   logic        Reset, LdReq, LdUnsigned, MemAck;
   logic [31:0] LdAddr, MemRdata;
   logic [1:0]  LdSize;
   logic        LdReady, MemRd, LdValid, LdErr;
   logic [31:0] MemAddr, LdData;

   typedef struct {
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   load_extend_ctrl #(.TIMEOUT(TO)) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .LdReq      (LdReq),
      .LdAddr     (LdAddr),
      .LdSize     (LdSize),
      .LdUnsigned (LdUnsigned),
      .LdReady    (LdReady),
      .MemRd      (MemRd),
      .MemAddr    (MemAddr),
      .MemAck     (MemAck),
      .MemRdata   (MemRdata),
      .LdValid    (LdValid),
      .LdData     (LdData),
      .LdErr      (LdErr)
   );

   always #5 Clk = ~Clk;

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   function automatic logic [31:0] ref_ext(input logic [31:0] w, input logic [1:0] size,
                                           input logic [1:0] off, input logic uns);
      logic [7:0]  b;
      logic [15:0] h;
      b = 8'((w >> (8 * off)) & 32'hFF);
      h = 16'((w >> (off[1] ? 16 : 0)) & 32'hFFFF);
      if (size == 2'b00) return uns ? {24'd0, b} : 32'($signed(b));
      if (size == 2'b01) return uns ? {16'd0, h} : 32'($signed(h));
      return w;
   endfunction

   task automatic run_load(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                           input int waits, input bit do_ack, input logic [31:0] rdata,
                           input logic [31:0] exp_data, input logic exp_err,
                           input bit exp_mem, input bit poke, input string name);
      exp_t e;
      int   rd = 0;
      int   lat = 0;
      bit   seen = 0;
      int   exp_lat, exp_rd;
      exp_lat = !exp_mem ? 1 : (do_ack ? waits + 2 : int'(TO) + 1);
      exp_rd  = !exp_mem ? 0 : (do_ack ? waits + 1 : int'(TO));
      checks++;
      if (LdReady !== 1'b1) begin
         failures++; $display("FAIL %s ready_before got=%b want=1", name, LdReady);
      end
      LdReq = 1'b1; LdAddr = addr; LdSize = size; LdUnsigned = uns;
      sb.push_back('{exp_data, exp_err});
      step();
      LdReq = 1'b0; LdAddr = $urandom; LdSize = 2'($urandom); LdUnsigned = 1'($urandom);
      for (int k = 1; k <= 40; k++) begin
         lat = k;
         if (LdValid === 1'b1) begin
            seen = 1;
            break;
         end
         if (MemRd === 1'b1) begin
            rd++;
            checks++;
            if (MemAddr !== {addr[31:2], 2'b00}) begin
               failures++;
               $display("FAIL %s memaddr got=%h want=%h", name, MemAddr, {addr[31:2], 2'b00});
            end
         end
         MemAck   = do_ack && (k - 1 == waits);
         MemRdata = MemAck ? rdata : $urandom;
         LdReq    = poke;
         step();
         MemAck = 1'b0;
         LdReq  = 1'b0;
      end
      checks++;
      if (!seen) begin
         failures++; $display("FAIL %s ldvalid_bound got=none want=pulse", name);
         if (sb.size() != 0) e = sb.pop_front();
         return;
      end
      checks++;
      if (lat != exp_lat) begin
         failures++; $display("FAIL %s latency got=%0d want=%0d", name, lat, exp_lat);
      end
      checks++;
      if (rd != exp_rd) begin
         failures++; $display("FAIL %s memrd_cycles got=%0d want=%0d", name, rd, exp_rd);
      end
      e = sb.pop_front();
      checks++;
      if (LdData !== e.data) begin
         failures++; $display("FAIL %s lddata got=%h want=%h", name, LdData, e.data);
      end
      checks++;
      if (LdErr !== e.err) begin
         failures++; $display("FAIL %s lderr got=%b want=%b", name, LdErr, e.err);
      end
      checks++;
      if (LdReady !== 1'b0 || MemRd !== 1'b0) begin
         failures++;
         $display("FAIL %s resp_ctl got=ready%b/rd%b want=ready0/rd0", name, LdReady, MemRd);
      end
      step();
      checks++;
      if (LdValid !== 1'b0 || LdReady !== 1'b1 || MemRd !== 1'b0) begin
         failures++;
         $display("FAIL %s after_resp got=v%b/ready%b/rd%b want=v0/ready1/rd0", name,
                  LdValid, LdReady, MemRd);
      end
      checks++;
      if (LdData !== e.data) begin
         failures++; $display("FAIL %s lddata_hold got=%h want=%h", name, LdData, e.data);
      end
   endtask

   task automatic test_reset();
      Reset = 1'b1; LdReq = 1'b0; LdAddr = '0; LdSize = '0; LdUnsigned = 1'b0;
      MemAck = 1'b0; MemRdata = '0;
      step();
      step();
      Reset = 1'b0;
      step();
      checks++;
      if ({LdReady, MemRd, LdValid, LdErr} !== 4'b1000 || MemAddr !== 32'd0 ||
          LdData !== 32'd0) begin
         failures++;
         $display("FAIL reset_state got=rdy%b rd%b v%b e%b a%h d%h want=rdy1 rd0 v0 e0 a0 d0",
                  LdReady, MemRd, LdValid, LdErr, MemAddr, LdData);
      end
   endtask

   task automatic test_lb_signed();
      run_load(32'h1003, 2'b00, 1'b0, 0, 1, 32'h80FF1234, 32'hFFFFFF80, 1'b0, 1, 0, "lb_signed");
   endtask

   task automatic test_half_pair();
      run_load(32'h2002, 2'b01, 1'b1, 0, 1, 32'h9ABC0011, 32'h00009ABC, 1'b0, 1, 0, "lhu");
      run_load(32'h2002, 2'b01, 1'b0, 0, 1, 32'h9ABC0011, 32'hFFFF9ABC, 1'b0, 1, 0, "lh");
   endtask

   task automatic test_lanes();
      logic [31:0] w;
      for (int off = 0; off < 4; off++) begin
         for (int u = 0; u < 2; u++) begin
            w = (off[0] ^ u[0]) ? 32'h7F80A55A : 32'h80FF1234;
            run_load(32'h3000 + 32'(off), 2'b00, u[0], 0, 1, w,
                     ref_ext(w, 2'b00, 2'(off), u[0]), 1'b0, 1, 0, "lane_byte");
         end
      end
      run_load(32'h3100, 2'b01, 1'b0, 1, 1, 32'h1234F00D, 32'hFFFFF00D, 1'b0, 1, 0, "lane_h0");
      run_load(32'h3100, 2'b01, 1'b1, 1, 1, 32'h1234F00D, 32'h0000F00D, 1'b0, 1, 0, "lane_hu0");
   endtask

   task automatic test_wait_states();
      run_load(32'h40, 2'b10, 1'b0, 3, 1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1, 1, "lw_wait");
   endtask

   task automatic test_errors();
      run_load(32'h101, 2'b01, 1'b0, 0, 0, 32'h0, 32'h0, 1'b1, 0, 0, "misalign_half");
      run_load(32'h102, 2'b10, 1'b0, 0, 0, 32'h0, 32'h0, 1'b1, 0, 0, "misalign_word");
      run_load(32'h200, 2'b11, 1'b0, 0, 0, 32'h0, 32'h0, 1'b1, 0, 0, "reserved_size");
   endtask

   task automatic test_timeout();
      run_load(32'h80, 2'b10, 1'b0, 0, 0, 32'h0, 32'h0, 1'b1, 1, 0, "timeout");
      run_load(32'h80, 2'b10, 1'b0, 3, 1, 32'h12345678, 32'h12345678, 1'b0, 1, 0,
               "ack_at_limit");
   endtask

   task automatic test_reset_mid_issue();
      LdReq = 1'b1; LdAddr = 32'h504; LdSize = 2'b10; LdUnsigned = 1'b0;
      step();
      LdReq = 1'b0;
      checks++;
      if (MemRd !== 1'b1) begin
         failures++; $display("FAIL rst_mid issue_memrd got=%b want=1", MemRd);
      end
      Reset = 1'b1;
      step();
      Reset = 1'b0; MemAck = 1'b1; MemRdata = 32'hCAFEF00D;
      checks++;
      if ({LdReady, MemRd, LdValid, LdErr} !== 4'b1000 || MemAddr !== 32'd0 ||
          LdData !== 32'd0) begin
         failures++;
         $display("FAIL rst_mid outputs got=rdy%b rd%b v%b e%b a%h d%h want=rdy1 rd0 v0 e0 a0 d0",
                  LdReady, MemRd, LdValid, LdErr, MemAddr, LdData);
      end
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (LdValid !== 1'b0 || MemRd !== 1'b0 || LdData !== 32'd0) begin
            failures++;
            $display("FAIL rst_mid late_ack got=v%b rd%b d%h want=v0 rd0 d0", LdValid, MemRd,
                     LdData);
         end
      end
      MemAck = 1'b0;
      checks++;
      if (sb.size() != 0) begin
         failures++; $display("FAIL scoreboard_left got=%0d want=0", sb.size());
      end
   endtask

   initial begin
      test_reset();
      test_lb_signed();
      test_half_pair();
      test_lanes();
      test_wait_states();
      test_errors();
      test_timeout();
      test_reset_mid_issue();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/load_extend_ctrl.md
Name: load_extend_ctrl

Overview:
- Sequencer for sub-word loads in the datapath. Accepts one load request at a time (byte, halfword or word, signed or unsigned) and issues a single word-aligned read to data memory over a req/ack handshake.
- Selects the addressed byte or halfword lane, sign- or zero-extends it to 32 bits, and returns the result with a one-cycle valid pulse.
- Sits between the MEM-stage control and the data memory. It replaces the fixed 8-bit/16-bit extenders on the load return path.

Parameters:
- TIMEOUT, 16, max cycles MemRd is held without MemAck before the load is aborted with error (legal range 1..255).

Ports:
- Clk  in  1  clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- LdReq  in  1  load request; accepted when LdReq && LdReady
- LdAddr  in  32  byte address of the load
- LdSize  in  2  00=byte, 01=half, 10=word, 11=reserved
- LdUnsigned  in  1  1=zero-extend, 0=sign-extend (ignored for word)
- LdReady  out  1  high only in IDLE
- MemRd  out  1  memory read strobe, held until ack or timeout
- MemAddr  out  32  word address: {captured addr[31:2], 2'b00}
- MemAck  in  1  memory ack; MemRdata valid in the same cycle
- MemRdata  in  32  memory read word
- LdValid  out  1  one-cycle pulse: LdData/LdErr valid
- LdData  out  32  extended load result; held until next LdValid
- LdErr  out  1  qualified by LdValid: misaligned, reserved size or timeout

Behaviour:
- Reset values:
  - State IDLE.
  - LdReady=1 (registered IDLE decode, so 1 the cycle after reset).
  - MemRd=0, MemAddr=0, LdValid=0, LdData=0, LdErr=0.
  - Timeout counter=0.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - On LdReq, capture LdAddr, LdSize and LdUnsigned.
  - Error check: misaligned is (half && addr[0]) or (word && addr[1:0]!=0). A misaligned or reserved-size request goes to RESP with the error flag set and no memory access.
  - Otherwise go to ISSUE.
- ISSUE:
  - MemRd=1 and MemAddr stable for the whole state.
  - Counter increments each ISSUE cycle.
  - MemAck=1: latch MemRdata into the extender, go to RESP.
  - No ack and counter==TIMEOUT-1: go to RESP with error; MemRd is 0 from the next cycle.
- RESP:
  - LdValid=1 for exactly one cycle.
  - LdData = extended value, or 0 on error. LdErr set accordingly.
  - Next state is IDLE. The counter clears.
- Latency:
  - Accept in cycle N, ack in N+1 gives LdValid in N+2 (2 cycles minimum).
  - Error path: LdValid in N+1.
  - Each wait cycle adds one.
- Throughput: at most one load per 3 cycles. LdReady=0 in ISSUE and RESP; LdReq is ignored there.
- Lane selection is little-endian:
  - byte k = MemRdata[8k+7:8k], with k = addr[1:0].
  - half = addr[1] ? [31:16] : [15:0].
  - word passes through unchanged.
- Extension fills bits above the lane width with the lane MSB (signed) or with 0 (unsigned).
- MemAck outside ISSUE is ignored. An ack arriving in the same cycle the timeout fires counts as success (ack has priority).
- Reset mid-operation aborts with no LdValid. MemRd is 0 in the cycle after the Reset edge, and a late MemAck is ignored.

Decomposition:
- Shared package (ld_pkg):
  - Size encodings LD_BYTE=2'b00, LD_HALF=2'b01, LD_WORD=2'b10, LD_RSVD=2'b11.
  - FSM state encoding.
- Sub-module load_lane_extend: combinational. Inputs data[31:0], off[1:0], size[1:0], unsigned; output out[31:0]. It holds all lane-select and extension logic and is unit-testable on its own.
- The controller holds the FSM, capture registers, counter and output registers.

Test Plan:
- LB signed:
  - Stimulus: LdAddr=0x1003, LdSize=00, LdUnsigned=0; MemAck in the first ISSUE cycle with MemRdata=0x80FF1234.
  - Required: MemAddr=0x1000; LdValid 2 cycles after accept; LdData=0xFFFFFF80; LdErr=0.
- LHU and LH, same word:
  - Stimulus: addr 0x2002, MemRdata=0x9ABC0011.
  - Required: unsigned gives LdData=0x00009ABC; signed gives 0xFFFF9ABC.
- Wait states:
  - Stimulus: LW addr 0x40; MemAck held low 3 cycles, then high with 0xDEADBEEF.
  - Required: MemRd high for 4 cycles; LdData=0xDEADBEEF; LdReq pulsed while busy is ignored.
- Misaligned and reserved:
  - Stimulus: LH at 0x101; LW at 0x102; LdSize=11.
  - Required: each gives LdValid 1 cycle after accept with LdErr=1, LdData=0, and MemRd never asserted.
- Timeout:
  - Stimulus: TIMEOUT=4, MemAck never asserted.
  - Required: MemRd high exactly 4 cycles, then LdValid with LdErr=1. Second run with ack on the 4th cycle gives LdErr=0.
- Reset mid-ISSUE:
  - Stimulus: Reset for 1 cycle during ISSUE, then MemAck=1.
  - Required: MemRd=0 the cycle after Reset; no LdValid; LdReady=1; all outputs at reset values.
